// File: rtl/div_seq.sv
// Sequential non-restoring integer divider, STEPS quotient bits per clock, with signed/unsigned operation.
// Optional define DIV_SEQ_DBZ_EN: a zero divisor skips iteration and flags oDBZ.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iQ,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ,
    output logic [WIDTH-1:0] oR,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDBZ
);

    localparam int NITER = WIDTH / STEPS;
    localparam int CW    = $clog2(NITER + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic             r_sq;
    logic             r_sd;
    logic [WIDTH-1:0] r_oq;
    logic [WIDTH-1:0] r_or;
    logic             r_busy;
    logic             r_done;

    logic             w_sq;
    logic             w_sd;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_d_mag;
    logic [WIDTH:0]   w_d_ext;
    logic [WIDTH:0]   w_a_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_neg;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_quo;

    assign w_sq    = iSigned & iQ[WIDTH-1];
    assign w_sd    = iSigned & iD[WIDTH-1];
    assign w_q_mag = w_sq ? -iQ : iQ;
    assign w_d_mag = w_sd ? -iD : iD;
    assign w_d_ext = {1'b0, r_d};

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        w_a_nxt = r_a;
        w_q_nxt = r_q;
        w_neg   = 1'b0;
        for (int s = 0; s < STEPS; s++) begin
            w_neg   = w_a_nxt[WIDTH];
            w_a_nxt = {w_a_nxt[WIDTH-1:0], w_q_nxt[WIDTH-1]};
            w_q_nxt = {w_q_nxt[WIDTH-2:0], 1'b0};
            w_a_nxt = w_neg ? (w_a_nxt + w_d_ext) : (w_a_nxt - w_d_ext);
            w_q_nxt[0] = ~w_a_nxt[WIDTH];
        end
    end

    // A negative partial remainder is corrected by one add-back; only the low WIDTH bits survive.
    assign w_rem_mag = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_d) : r_a[WIDTH-1:0];
    assign w_rem     = r_sq ? -w_rem_mag : w_rem_mag;
    assign w_quo     = (r_sq ^ r_sd) ? -r_q : r_q;

`ifdef DIV_SEQ_DBZ_EN
    logic r_dbz_pend;
    logic r_dbz;
`endif

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_sq    <= 1'b0;
            r_sd    <= 1'b0;
            r_oq    <= '0;
            r_or    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef DIV_SEQ_DBZ_EN
            r_dbz_pend <= 1'b0;
            r_dbz      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (iStart) begin
                        r_sq    <= w_sq;
                        r_sd    <= w_sd;
                        r_a     <= '0;
                        r_q     <= w_q_mag;
                        r_d     <= w_d_mag;
                        r_cnt   <= CW'(NITER);
                        r_busy  <= 1'b1;
                        r_state <= ITER;
`ifdef DIV_SEQ_DBZ_EN
                        r_dbz_pend <= (iD == '0);
                        if (iD == '0) begin
                            r_q     <= iQ;
                            r_state <= FIX;
                        end
`endif
                    end
                end
                ITER: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_oq    <= w_quo;
                    r_or    <= w_rem;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
`ifdef DIV_SEQ_DBZ_EN
                    // The raw dividend was parked in r_q when the zero divisor was seen.
                    if (r_dbz_pend) begin
                        r_oq <= '1;
                        r_or <= r_q;
                    end
                    r_dbz <= r_dbz_pend;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oQ    = r_oq;
    assign oR    = r_or;
    assign oBusy = r_busy;
    assign oDone = r_done;
`ifdef DIV_SEQ_DBZ_EN
    assign oDBZ  = r_dbz;
`else
    assign oDBZ  = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected results are queued at issue and compared when oDone pulses.
// Covers DIV_SEQ_DBZ_EN behaviour when that macro is defined for the build.
module tb_div_seq;

    localparam int W     = 32;
    localparam int STEPS = 1;
    localparam int LAT   = W / STEPS + 1;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         iClk = 1'b0;
    logic         iRst;
    logic         iStart;
    logic         iSigned;
    logic [W-1:0] iQ;
    logic [W-1:0] iD;
    logic [W-1:0] oQ;
    logic [W-1:0] oR;
    logic         oBusy;
    logic         oDone;
    logic         oDBZ;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div_seq #(.WIDTH(W), .STEPS(STEPS)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iSigned (iSigned),
        .iQ      (iQ),
        .iD      (iD),
        .oQ      (oQ),
        .oR      (oR),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oDBZ    (oDBZ)
    );

    always #5 iClk = ~iClk;

    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] d);
        exp_t e;
        e.dbz = 1'b0;
`ifdef DIV_SEQ_DBZ_EN
        if (d == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            return e;
        end
`endif
        if (!s) begin
            e.q = a / d;
            e.r = a % d;
        end else if (a == MIN && d == '1) begin
            e.q = MIN;
            e.r = '0;
        end else begin
            e.q = $signed(a) / $signed(d);
            e.r = $signed(a) % $signed(d);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Drives one request; when now=1 it is presented in the current cycle (e.g. the oDone cycle).
    task automatic issue(input bit now, input logic s, input logic [W-1:0] a, input logic [W-1:0] d);
        if (!now) @(negedge iClk);
        iStart  = 1'b1;
        iSigned = s;
        iQ      = a;
        iD      = d;
        sb.push_back(model(s, a, d));
        @(posedge iClk);
        #1;
        iStart  = 1'b0;
        iSigned = 1'($urandom);
        iQ      = $urandom;
        iD      = $urandom;
        @(negedge iClk);
        check("busy_after_accept", W'(oBusy), 32'd1);
    endtask

    // Counts edges from the accept edge until oDone is seen, then compares against the scoreboard.
    task automatic wait_done(input int exp_lat, input string tag);
        int   n;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge iClk);
            n++;
            @(negedge iClk);
            seen = oDone;
        end
        check({tag, "_lat"}, W'(n), W'(exp_lat));
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_q"}, oQ, e.q);
            check({tag, "_r"}, oR, e.r);
            check({tag, "_dbz"}, W'(oDBZ), W'(e.dbz));
            check({tag, "_busy"}, W'(oBusy), 32'd0);
        end
    endtask

    initial begin
        iRst    = 1'b1;
        iStart  = 1'b0;
        iSigned = 1'b0;
        iQ      = '0;
        iD      = '0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check("rst_q", oQ, 32'd0);
        check("rst_r", oR, 32'd0);
        check("rst_busy", W'(oBusy), 32'd0);
        check("rst_done", W'(oDone), 32'd0);
        check("rst_dbz", W'(oDBZ), 32'd0);
        iRst = 1'b0;

        issue(1'b0, 1'b0, 32'd100, 32'd7);
        wait_done(LAT, "u100_7");
        @(negedge iClk);
        check("done_pulse", W'(oDone), 32'd0);
        check("hold_q", oQ, 32'd14);
        check("hold_r", oR, 32'd2);

        issue(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done(LAT, "sneg100_7");
        issue(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_done(LAT, "s100_neg7");
        issue(1'b0, 1'b1, MIN, 32'hFFFF_FFFF);
        wait_done(LAT, "smin_neg1");
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done(LAT, "umax_1");
        issue(1'b0, 1'b0, 32'd5, 32'd9);
        wait_done(LAT, "u5_9");
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        wait_done(LAT, "sneg7_neg2");

        for (int i = 0; i < 6; i++) begin
            logic         s;
            logic [W-1:0] a;
            logic [W-1:0] d;
            s = 1'($urandom);
            a = $urandom;
            d = (i % 2 == 1) ? W'($urandom_range(1, 1000)) : W'($urandom);
            if (d == '0) d = 32'd1;
            issue(1'b0, s, a, d);
            wait_done(LAT, "random");
        end

        // Requests while busy must be dropped without disturbing the result in flight.
        issue(1'b0, 1'b0, 32'd1000, 32'd3);
        for (int i = 1; i <= LAT - 1; i++) begin
            iStart  = 1'b1;
            iSigned = 1'($urandom);
            iQ      = $urandom;
            iD      = $urandom | 32'd1;
            @(posedge iClk);
            @(negedge iClk);
        end
        iStart = 1'b0;
        check("busy_in_fix", W'(oBusy), 32'd1);
        wait_done(1, "ignore_start");

        issue(1'b1, 1'b1, 32'd12345, 32'hFFFF_FFEF);
        wait_done(LAT, "b2b");

        issue(1'b0, 1'b0, 32'hDEAD_BEEF, 32'd3);
        repeat (9) @(negedge iClk);
        iRst = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        check("midrst_busy", W'(oBusy), 32'd0);
        check("midrst_done", W'(oDone), 32'd0);
        check("midrst_q", oQ, 32'd0);
        check("midrst_r", oR, 32'd0);
        void'(sb.pop_back());
        iRst = 1'b0;
        issue(1'b0, 1'b0, 32'd77, 32'd5);
        wait_done(LAT, "after_rst");

`ifdef DIV_SEQ_DBZ_EN
        issue(1'b0, 1'b0, 32'h0000_1234, 32'd0);
        wait_done(1, "dbz");
        issue(1'b0, 1'b0, 32'd50, 32'd5);
        wait_done(LAT, "after_dbz");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
